// File: rtl/transcription_sequencer_pkg.sv
// Shared types and constants for the note transcription sequencer.
package transcription_pkg;

    localparam int unsigned NUM_SLOTS = 160;
    localparam int unsigned NOTE_W    = 6;
    localparam int unsigned ADDR_W    = 8;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StCountIn,
        StCapture,
        StDone
    } state_t;

endpackage

// File: rtl/transcription_sequencer_if.sv
// Control/note inputs and note-store write bus of the transcription sequencer.
interface transcription_sequencer_if #(
    parameter int unsigned PERIOD_W = 26
);

    logic                               arm_in;
    logic [PERIOD_W-1:0]                period_in;
    logic [transcription_pkg::NOTE_W-1:0] note_in;
    logic                               note_valid_in;
    logic                               wr_en_out;
    logic [transcription_pkg::ADDR_W-1:0] wr_addr_out;
    logic [transcription_pkg::NOTE_W-1:0] wr_data_out;
    logic                               beat_out;
    logic                               busy_out;
    logic                               done_out;

    modport master (
        output arm_in, period_in, note_in, note_valid_in,
        input  wr_en_out, wr_addr_out, wr_data_out, beat_out, busy_out, done_out
    );

    modport slave (
        input  arm_in, period_in, note_in, note_valid_in,
        output wr_en_out, wr_addr_out, wr_data_out, beat_out, busy_out, done_out
    );

endinterface

// File: rtl/transcription_sequencer_eighth_timer.sv
// Eighth-note timer: clamped period latch and wrapping tick counter with boundary strobe.
module eighth_timer #(
    parameter int unsigned PERIOD_W   = 26,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                load_i,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                boundary_o
);

    localparam logic [PERIOD_W-1:0] MinP = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    assign boundary_o = en_i && !clear_i && (cnt_q == period_q - PERIOD_W'(1));

    always_comb begin
        period_d = period_q;
        if (load_i) begin
            period_d = (period_i < MinP) ? MinP : period_i;
        end
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = boundary_o ? '0 : cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            period_q <= MinP;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/transcription_sequencer.sv
// Recording sequencer: clears the note store, plays a count-in, then captures one note per eighth.
module transcription_sequencer
    import transcription_pkg::*;
#(
    parameter int unsigned PERIOD_W   = 26,
    parameter int unsigned COUNT_IN   = 8,
    parameter int unsigned MIN_PERIOD = 2
) (
    input logic                      clk_in,
    input logic                      rst_in,
    transcription_sequencer_if.slave bus
);

    localparam logic [ADDR_W-1:0] LastSlot = ADDR_W'(NUM_SLOTS - 1);

    state_t              state_q, state_d;
    logic                arm_q;
    logic [ADDR_W-1:0]   slot_q, slot_d;
    logic [NOTE_W-1:0]   held_q, held_d;
    logic                seen_q, seen_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [NOTE_W-1:0]   wr_data_q, wr_data_d;
    logic                beat_q, beat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                arm_rise, boundary, timer_en;

    assign arm_rise = bus.arm_in && !arm_q;
    assign timer_en = (state_q == StCountIn) || (state_q == StCapture);

    eighth_timer #(
        .PERIOD_W   (PERIOD_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .load_i     ((state_q == StIdle) && arm_rise),
        .clear_i    (!timer_en),
        .en_i       (timer_en),
        .period_i   (bus.period_in),
        .boundary_o (boundary)
    );

    // arm_q tracks arm_in even in reset so a level held across reset release is not an edge.
    always_ff @(posedge clk_in) begin
        arm_q <= bus.arm_in;
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (arm_rise) state_d = StClear;
            StClear: begin
                if (!bus.arm_in) state_d = StIdle;
                else if (slot_q == LastSlot) state_d = (COUNT_IN == 0) ? StCapture : StCountIn;
            end
            StCountIn: begin
                if (!bus.arm_in) state_d = StIdle;
                else if (boundary && (32'(slot_q) + 1 >= COUNT_IN)) state_d = StCapture;
            end
            StCapture: begin
                if (!bus.arm_in) state_d = StIdle;
                else if (boundary && slot_q == LastSlot) state_d = StDone;
            end
            StDone:    if (!bus.arm_in) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        slot_d    = slot_q;
        held_d    = held_q;
        seen_d    = seen_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        beat_d    = 1'b0;
        busy_d    = (state_d == StClear) || (state_d == StCountIn) || (state_d == StCapture);
        done_d    = (state_d == StDone);
        unique case (state_q)
            StClear: if (bus.arm_in) begin
                wr_en_d   = 1'b1;
                wr_addr_d = slot_q;
                wr_data_d = REST_NOTE;
                slot_d    = (slot_q == LastSlot) ? '0 : slot_q + ADDR_W'(1);
            end
            StCountIn: if (bus.arm_in && boundary) begin
                beat_d = 1'b1;
                slot_d = (state_d == StCapture) ? '0 : slot_q + ADDR_W'(1);
            end
            StCapture: if (bus.arm_in) begin
                if (bus.note_valid_in) begin
                    held_d = bus.note_in;
                    seen_d = 1'b1;
                end
                // A strobe on the boundary cycle still belongs to the slot that is ending.
                if (boundary) begin
                    beat_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = slot_q;
                    wr_data_d = bus.note_valid_in ? bus.note_in : (seen_q ? held_q : REST_NOTE);
                    held_d    = REST_NOTE;
                    seen_d    = 1'b0;
                    slot_d    = slot_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
        if (state_d == StIdle) begin
            slot_d = '0;
            held_d = REST_NOTE;
            seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_q    <= '0;
            held_q    <= REST_NOTE;
            seen_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            beat_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            held_q    <= held_d;
            seen_q    <= seen_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            beat_q    <= beat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.wr_en_out   = wr_en_q;
    assign bus.wr_addr_out = wr_addr_q;
    assign bus.wr_data_out = wr_data_q;
    assign bus.beat_out    = beat_q;
    assign bus.busy_out    = busy_q;
    assign bus.done_out    = done_q;

endmodule

// File: tb/tb_transcription_sequencer.sv
// Bench for transcription_sequencer: write scoreboard, per-slot vector table, corner sequences.
module tb_transcription_sequencer;

    typedef struct packed {
        logic [7:0] addr;
        logic [5:0] data;
    } wr_t;

    typedef struct {
        logic [5:0] na;
        int         oa;
        logic [5:0] nb;
        int         ob;
        logic [5:0] exp;
    } slot_vec_t;

    logic clk = 1'b0;
    logic rst_in;
    int   total = 0;
    int   bad = 0;
    int   nwr = 0;
    int   cur_p = 10;
    bit   mon_en = 1'b0;
    wr_t  sb_q[$];
    slot_vec_t vecs[8];

    transcription_sequencer_if #(.PERIOD_W(26)) bus ();

    transcription_sequencer #(
        .PERIOD_W   (26),
        .COUNT_IN   (2),
        .MIN_PERIOD (2)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beat(output int k);
        k = 0;
        do begin
            step();
            k++;
        end while (bus.beat_out !== 1'b1 && k < 2000);
        if (bus.beat_out !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: no beat_out within %0d cycles", k);
        end
    endtask

    task automatic push_clear();
        for (int i = 0; i < 160; i++) sb_q.push_back('{addr: 8'(i), data: 6'd0});
    endtask

    // Called on the first cycle of a capture slot; returns on the first cycle of the next.
    task automatic run_slot(input logic [5:0] na, input int oa, input logic [5:0] nb, input int ob,
                            input logic [5:0] exp, input int addr);
        sb_q.push_back('{addr: 8'(addr), data: exp});
        for (int o = 0; o < cur_p; o++) begin
            bus.note_valid_in = 1'b0;
            bus.note_in       = 6'd0;
            if (o == oa) begin
                bus.note_in = na;
                bus.note_valid_in = 1'b1;
            end
            if (o == ob) begin
                bus.note_in = nb;
                bus.note_valid_in = 1'b1;
            end
            step();
        end
        bus.note_valid_in = 1'b0;
        bus.note_in       = 6'd0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.wr_en_out === 1'b1) begin
                nwr++;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0d want no write",
                             bus.wr_addr_out, bus.wr_data_out);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("wr_addr", 32'(bus.wr_addr_out), 32'(e.addr));
                    check("wr_data", 32'(bus.wr_data_out), 32'(e.data));
                end
            end else begin
                check("idle_bus_zero", {18'd0, bus.wr_addr_out, bus.wr_data_out}, 32'd0);
            end
        end
    end

    initial begin
        int k;
        int w0;
        vecs[0] = '{6'd17, 2, 6'd23, 5, 6'd23};
        vecs[1] = '{6'd0, -1, 6'd0, -1, 6'd0};
        vecs[2] = '{6'd9, 9, 6'd0, -1, 6'd9};
        vecs[3] = '{6'd0, -1, 6'd0, -1, 6'd0};
        vecs[4] = '{6'd5, 0, 6'd0, -1, 6'd5};
        vecs[5] = '{6'd40, 3, 6'd2, 8, 6'd2};
        vecs[6] = '{6'd12, 0, 6'd33, 9, 6'd33};
        vecs[7] = '{6'd0, -1, 6'd0, -1, 6'd0};

        rst_in = 1'b1;
        bus.arm_in = 1'b0;
        bus.period_in = 26'd10;
        bus.note_in = 6'd0;
        bus.note_valid_in = 1'b0;
        repeat (3) step();
        check("reset_outputs", {22'd0, bus.wr_en_out, bus.wr_addr_out, bus.wr_data_out,
              bus.beat_out, bus.busy_out, bus.done_out}, 32'd0);
        rst_in = 1'b0;
        mon_en = 1'b1;
        step();

        // Clear, count-in and the vector table at P=10.
        w0 = nwr;
        bus.arm_in = 1'b1;
        push_clear();
        wait_beat(k);
        check("first_beat_latency", 32'(k), 32'd171);
        check("clear_write_count", 32'(nwr - w0), 32'd160);
        check("busy_in_countin", 32'(bus.busy_out), 32'd1);
        wait_beat(k);
        check("countin_beat_spacing", 32'(k), 32'd10);
        check("no_countin_writes", 32'(nwr - w0), 32'd160);
        for (int i = 0; i < 8; i++) begin
            run_slot(vecs[i].na, vecs[i].oa, vecs[i].nb, vecs[i].ob, vecs[i].exp, i);
            if (i == 0) begin
                check("first_write_10_after_beat", 32'(bus.wr_en_out), 32'd1);
                check("beat_with_first_write", 32'(bus.beat_out), 32'd1);
            end
        end
        for (int s = 8; s < 160; s++) run_slot(6'd0, -1, 6'd0, -1, 6'd0, s);
        step();
        check("done_after_last", 32'(bus.done_out), 32'd1);
        check("not_busy_in_done", 32'(bus.busy_out), 32'd0);
        check("all_slots_written", 32'(sb_q.size()), 32'd0);
        repeat (5) step();
        bus.arm_in = 1'b0;
        step();
        step();
        check("done_cleared_on_disarm", 32'(bus.done_out), 32'd0);

        // Abort on the boundary cycle of slot 40.
        step();
        bus.arm_in = 1'b1;
        push_clear();
        wait_beat(k);
        wait_beat(k);
        for (int s = 0; s < 40; s++) run_slot(6'd0, -1, 6'd0, -1, 6'd0, s);
        bus.note_in = 6'd21;
        bus.note_valid_in = 1'b1;
        repeat (9) step();
        bus.arm_in = 1'b0;
        step();
        bus.note_valid_in = 1'b0;
        check("abort_busy_low", 32'(bus.busy_out), 32'd0);
        check("abort_no_write", 32'(bus.wr_en_out), 32'd0);
        check("abort_done_low", 32'(bus.done_out), 32'd0);
        repeat (5) step();

        // Reset during CLEAR, then arm held high across reset release.
        bus.arm_in = 1'b1;
        sb_q.push_back('{addr: 8'd0, data: 6'd0});
        sb_q.push_back('{addr: 8'd1, data: 6'd0});
        repeat (3) step();
        rst_in = 1'b1;
        step();
        check("midop_reset_outputs", {22'd0, bus.wr_en_out, bus.wr_addr_out, bus.wr_data_out,
              bus.beat_out, bus.busy_out, bus.done_out}, 32'd0);
        check("midop_writes_seen", 32'(sb_q.size()), 32'd0);
        rst_in = 1'b0;
        repeat (20) step();
        check("held_arm_stays_idle", 32'(bus.busy_out), 32'd0);

        // period_in=0 clamps to 2.
        bus.arm_in = 1'b0;
        bus.period_in = 26'd0;
        step();
        bus.arm_in = 1'b1;
        push_clear();
        wait_beat(k);
        check("clamped_first_beat", 32'(k), 32'd163);
        wait_beat(k);
        check("clamped_beat_spacing", 32'(k), 32'd2);
        cur_p = 2;
        run_slot(6'd7, 0, 6'd0, -1, 6'd7, 0);
        run_slot(6'd11, 1, 6'd0, -1, 6'd11, 1);
        check("clamped_beat_slot2", 32'(bus.beat_out), 32'd1);
        bus.arm_in = 1'b0;
        step();
        step();
        check("final_idle", 32'(bus.busy_out), 32'd0);
        repeat (3) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
